// File: rtl/dmem_pkg.sv
// Shared size encodings, FSM state type and read latency for the banked data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam int unsigned RD_LATENCY = 2;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    function automatic int unsigned size_bytes(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: return 1;
            SZ_HALF: return 2;
            SZ_WORD: return 4;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/bram.sv
// Single-port byte-wide synchronous RAM bank, read-first, one-cycle read latency.
module bram #(
    parameter int unsigned AW = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [7:0]    i_wdata,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [2**AW];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        o_rdata <= r_mem[i_addr];
    end

endmodule

// File: rtl/dmem_align.sv
// Byte-lane rotate, byte-enable, legality and load extension for dmem_banked.
// Macro DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into illegal accesses.
module dmem_align
    import dmem_pkg::*;
#(
    parameter  int unsigned NB_BANKS = 4,
    localparam int unsigned LG       = $clog2(NB_BANKS),
    localparam int unsigned DW       = 8 * NB_BANKS
) (
    input  logic [LG-1:0]       i_off,
    input  logic [1:0]          i_size,
    input  logic [DW-1:0]       i_wdata,
    output logic                o_illegal,
    output logic [NB_BANKS-1:0] o_be,
    output logic [NB_BANKS-1:0] o_inc,
    output logic [DW-1:0]       o_wdata,
    input  logic [LG-1:0]       i_ld_off,
    input  logic [1:0]          i_ld_size,
    input  logic                i_ld_unsigned,
    input  logic [DW-1:0]       i_ld_raw,
    output logic [DW-1:0]       o_ld_data
);

    logic [3:0]    w_nb;
    logic [3:0]    w_ld_nb;
    logic [LG-1:0] w_k;
    logic [LG-1:0] w_bank;
    logic [7:0]    w_byte;
    logic          w_sign;

    // Bank b holds byte k = (b - offset) mod NB_BANKS of the access.
    always_comb begin
        w_nb      = 4'(size_bytes(i_size));
        o_illegal = (w_nb == '0) || (w_nb > 4'(NB_BANKS));
`ifdef DMEM_MISALIGN_TRAP_EN
        if ((i_size == SZ_HALF && i_off[0]) || (i_size == SZ_WORD && i_off != '0)) begin
            o_illegal = 1'b1;
        end
`endif
        o_be    = '0;
        o_inc   = '0;
        o_wdata = '0;
        w_k     = '0;
        for (int unsigned b = 0; b < NB_BANKS; b++) begin
            w_k                = LG'(b) - i_off;
            o_be[b]            = 4'(w_k) < w_nb;
            o_inc[b]           = LG'(b) < i_off;
            o_wdata[8*b +: 8]  = i_wdata[{w_k, 3'b000} +: 8];
        end
    end

    always_comb begin
        w_ld_nb   = 4'(size_bytes(i_ld_size));
        w_sign    = 1'b0;
        w_bank    = '0;
        w_byte    = '0;
        o_ld_data = '0;
        for (int unsigned k = 0; k < NB_BANKS; k++) begin
            w_bank = LG'(k) + i_ld_off;
            w_byte = i_ld_raw[{w_bank, 3'b000} +: 8];
            if (4'(k) < w_ld_nb) begin
                o_ld_data[8*k +: 8] = w_byte;
                w_sign              = w_byte[7];
            end
        end
        for (int unsigned k = 0; k < NB_BANKS; k++) begin
            if (!(4'(k) < w_ld_nb)) begin
                o_ld_data[8*k +: 8] = {8{w_sign & ~i_ld_unsigned}};
            end
        end
    end

endmodule

// File: rtl/dmem_banked.sv
// Byte-banked data memory with unaligned/wrapping access, 2-cycle pipelined loads and clear-after-reset.
// Macro DMEM_MISALIGN_TRAP_EN (in dmem_align) makes misaligned accesses illegal.
module dmem_banked
    import dmem_pkg::*;
#(
    parameter  int unsigned ADDR_WIDTH     = 10,
    parameter  int unsigned NB_BANKS       = 4,
    parameter  bit          CLEAR_ON_RESET = 1'b1,
    localparam int unsigned DW             = 8 * NB_BANKS,
    localparam int unsigned LG             = $clog2(NB_BANKS),
    localparam int unsigned BW             = ADDR_WIDTH - LG
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_req,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_size,
    input  logic                  i_unsigned,
    input  logic [DW-1:0]         i_wdata,
    output logic                  o_ready,
    output logic                  o_rvalid,
    output logic [DW-1:0]         o_rdata,
    output logic                  o_err
);

    state_t                r_state, w_next;
    logic [BW-1:0]         r_clr_cnt;
    logic                  w_clearing;
    logic                  w_accept;
    logic                  w_illegal;
    logic [NB_BANKS-1:0]   w_be, w_inc;
    logic [DW-1:0]         w_wdata_rot, w_raw, w_ld_data;
    logic [BW-1:0]         w_base;

    logic [RD_LATENCY-1:0] r_vld_sr, r_err_sr;
    logic [LG-1:0]         r_ld_off;
    logic [1:0]            r_ld_size;
    logic                  r_ld_uns;
    logic [DW-1:0]         r_ld_data;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
            r_clr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == ST_CLEAR) begin
                r_clr_cnt <= r_clr_cnt + BW'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_CLEAR: if (r_clr_cnt == '1) w_next = ST_RUN;
            ST_RUN:   w_next = ST_RUN;
            default:  w_next = ST_RUN;
        endcase
    end

    // Ready is gated by reset so it stays low in reset even when the reset state is RUN.
    always_comb begin
        o_ready    = (r_state == ST_RUN) && i_rst_n;
        w_clearing = (r_state == ST_CLEAR);
    end

    assign w_accept = i_req && o_ready;
    assign w_base   = i_addr[ADDR_WIDTH-1:LG];

    dmem_align #(.NB_BANKS(NB_BANKS)) u_align (
        .i_off         (i_addr[LG-1:0]),
        .i_size        (i_size),
        .i_wdata       (i_wdata),
        .o_illegal     (w_illegal),
        .o_be          (w_be),
        .o_inc         (w_inc),
        .o_wdata       (w_wdata_rot),
        .i_ld_off      (r_ld_off),
        .i_ld_size     (r_ld_size),
        .i_ld_unsigned (r_ld_uns),
        .i_ld_raw      (w_raw),
        .o_ld_data     (w_ld_data)
    );

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        logic [BW-1:0] w_bank_addr;
        logic          w_bank_we;
        logic [7:0]    w_bank_wd;

        // Word index wraps in BW bits, giving modulo-depth wrap at the top of memory.
        always_comb begin
            w_bank_addr = w_clearing ? r_clr_cnt : w_base + BW'(w_inc[b]);
            w_bank_we   = w_clearing || (w_accept && i_we && !w_illegal && w_be[b]);
            w_bank_wd   = w_clearing ? '0 : w_wdata_rot[8*b +: 8];
        end

        bram #(.AW(BW)) u_bank (
            .clk     (clk),
            .i_we    (w_bank_we),
            .i_addr  (w_bank_addr),
            .i_wdata (w_bank_wd),
            .o_rdata (w_raw[8*b +: 8])
        );
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_vld_sr  <= '0;
            r_err_sr  <= '0;
            r_ld_off  <= '0;
            r_ld_size <= '0;
            r_ld_uns  <= 1'b0;
            r_ld_data <= '0;
            o_rvalid  <= 1'b0;
            o_err     <= 1'b0;
            o_rdata   <= '0;
        end else begin
            r_vld_sr  <= {r_vld_sr[RD_LATENCY-2:0], w_accept && !i_we && !w_illegal};
            r_err_sr  <= {r_err_sr[RD_LATENCY-2:0], w_accept && w_illegal};
            if (w_accept) begin
                r_ld_off  <= i_addr[LG-1:0];
                r_ld_size <= i_size;
                r_ld_uns  <= i_unsigned;
            end
            r_ld_data <= w_ld_data;
            o_rvalid  <= r_vld_sr[RD_LATENCY-1];
            o_err     <= r_err_sr[RD_LATENCY-1];
            o_rdata   <= r_vld_sr[RD_LATENCY-1] ? r_ld_data : '0;
        end
    end

endmodule

// File: tb/tb_dmem_banked.sv
// Self-checking bench for dmem_banked: directed vector table, reset/clear sequences, randomized traffic vs byte-array model.
module tb_dmem_banked;

    localparam int AW    = 10;
    localparam int DEPTH = 1 << AW;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_req = 1'b0;
    logic        i_we = 1'b0;
    logic [9:0]  i_addr = '0;
    logic [1:0]  i_size = '0;
    logic        i_unsigned = 1'b0;
    logic [31:0] i_wdata = '0;
    logic        o_ready;
    logic        o_rvalid;
    logic [31:0] o_rdata;
    logic        o_err;

    dmem_banked #(.ADDR_WIDTH(AW), .NB_BANKS(4), .CLEAR_ON_RESET(1)) dut (
        .clk        (clk),
        .i_rst_n    (i_rst_n),
        .i_req      (i_req),
        .i_we       (i_we),
        .i_addr     (i_addr),
        .i_size     (i_size),
        .i_unsigned (i_unsigned),
        .i_wdata    (i_wdata),
        .o_ready    (o_ready),
        .o_rvalid   (o_rvalid),
        .o_rdata    (o_rdata),
        .o_err      (o_err)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] mem [DEPTH];

    typedef struct packed {
        logic        v;
        logic        e;
        logic [31:0] d;
    } resp_t;

    resp_t pend[$];

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wd;
        logic        ev;
        logic        ee;
        logic [31:0] ed;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_req = 1'b0; i_we = 1'b0; i_addr = '0; i_size = '0; i_unsigned = 1'b0; i_wdata = '0;
    endtask

    function automatic int nbytes(input logic [1:0] s);
        case (s)
            2'b01:   return 1;
            2'b10:   return 2;
            2'b11:   return 4;
            default: return 0;
        endcase
    endfunction

    function automatic bit legal(input logic [9:0] a, input logic [1:0] s);
        if (s == 2'b00) return 1'b0;
        if (TRAP && ((s == 2'b10 && a[0]) || (s == 2'b11 && a[1:0] != 2'b00))) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [9:0] a, input logic [1:0] s, input logic uns);
        logic [31:0] v;
        int n;
        v = '0;
        n = nbytes(s);
        for (int k = 0; k < n; k++) v[8*k +: 8] = mem[(int'(a) + k) % DEPTH];
        if (n > 0 && !uns && v[8*n-1]) for (int k = 8 * n; k < 32; k++) v[k] = 1'b1;
        return v;
    endfunction

    task automatic model_store(input logic [9:0] a, input logic [1:0] s, input logic [31:0] wd);
        for (int k = 0; k < nbytes(s); k++) mem[(int'(a) + k) % DEPTH] = wd[8*k +: 8];
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
        pend.delete();
        pend.push_back(resp_t'(0));
        pend.push_back(resp_t'(0));
    endtask

    function automatic vec_t mk(input logic we, input logic [9:0] a, input logic [1:0] s,
                                input logic uns, input logic [31:0] wd, input logic [31:0] ed);
        vec_t v;
        v.we = we; v.addr = a; v.size = s; v.uns = uns; v.wd = wd;
        v.ev = !we && legal(a, s);
        v.ee = !legal(a, s);
        v.ed = v.ev ? ed : 32'h0;
        return v;
    endfunction

    // One request per cycle; the response compared each cycle belongs to the request two cycles earlier.
    task automatic step(input string name, input logic req, input logic we, input logic [9:0] a,
                        input logic [1:0] s, input logic uns, input logic [31:0] wd);
        resp_t r;
        r = '0;
        i_req = req; i_we = we; i_addr = a; i_size = s; i_unsigned = uns; i_wdata = wd;
        if (req) begin
            if (!legal(a, s)) r.e = 1'b1;
            else if (!we) begin r.v = 1'b1; r.d = model_load(a, s, uns); end
            else model_store(a, s, wd);
        end
        pend.push_back(r);
        cyc();
        r = pend.pop_front();
        chk(name, 64'({o_rvalid, o_err, o_rdata}), 64'(r));
    endtask

    task automatic wait_ready(input string name);
        int k;
        for (k = 1; k <= 1000; k++) begin
            cyc();
            if (o_ready) break;
        end
        chk(name, 64'(k), 64'(256));
    endtask

    task automatic run_vec(input string name, input vec_t v);
        i_req = 1'b1; i_we = v.we; i_addr = v.addr; i_size = v.size; i_unsigned = v.uns; i_wdata = v.wd;
        cyc();
        idle();
        cyc();
        chk({name, "_early"}, 64'({o_rvalid, o_err}), 64'(0));
        cyc();
        chk({name, "_resp"}, 64'({o_rvalid, o_err, o_rdata}), 64'({v.ev, v.ee, v.ed}));
        cyc();
        chk({name, "_pulse"}, 64'({o_rvalid, o_err}), 64'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(1'b0, 10'h3FC, 2'b11, 1'b1, 32'h0, 32'h0000_0000);
        tbl[1]  = mk(1'b1, 10'h001, 2'b11, 1'b0, 32'hAABBCCDD, 32'h0);
        tbl[2]  = mk(1'b0, 10'h001, 2'b11, 1'b1, 32'h0, 32'hAABBCCDD);
        tbl[3]  = mk(1'b0, 10'h000, 2'b01, 1'b1, 32'h0, 32'h0000_0000);
        tbl[4]  = mk(1'b1, 10'h3FF, 2'b01, 1'b0, 32'h0000_0080, 32'h0);
        tbl[5]  = mk(1'b0, 10'h3FF, 2'b01, 1'b0, 32'h0, 32'hFFFF_FF80);
        tbl[6]  = mk(1'b0, 10'h3FF, 2'b01, 1'b1, 32'h0, 32'h0000_0080);
        tbl[7]  = mk(1'b1, 10'h3FF, 2'b10, 1'b0, 32'h0000_1234, 32'h0);
        tbl[8]  = mk(1'b0, 10'h3FF, 2'b01, 1'b1, 32'h0, TRAP ? 32'h80 : 32'h34);
        tbl[9]  = mk(1'b0, 10'h000, 2'b01, 1'b1, 32'h0, TRAP ? 32'h00 : 32'h12);
        tbl[10] = mk(1'b0, 10'h010, 2'b00, 1'b1, 32'h0, 32'h0);
        tbl[11] = mk(1'b1, 10'h000, 2'b00, 1'b0, 32'hFFFF_FFFF, 32'h0);
        tbl[12] = mk(1'b0, 10'h000, 2'b01, 1'b1, 32'h0, TRAP ? 32'h00 : 32'h12);
        tbl[13] = mk(1'b0, 10'h001, 2'b10, 1'b0, 32'h0, 32'hFFFF_CCDD);
        tbl[14] = mk(1'b0, 10'h3FE, 2'b11, 1'b1, 32'h0, 32'hDD12_3400);

        idle();
        i_rst_n = 1'b0;
        repeat (3) cyc();
        chk("reset_outputs", 64'({o_ready, o_rvalid, o_err, o_rdata}), 64'(0));
        i_rst_n = 1'b1;
        wait_ready("clear_length");

        for (int i = 0; i < 15; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset during CLEAR must restart the sweep from word 0.
        i_rst_n = 1'b0;
        cyc();
        i_rst_n = 1'b1;
        repeat (100) cyc();
        chk("mid_clear_ready", 64'(o_ready), 64'(0));
        i_rst_n = 1'b0;
        cyc(); cyc();
        i_rst_n = 1'b1;
        wait_ready("clear_restart_length");

        model_clear();
        step("b2b_st0", 1'b1, 1'b1, 10'h000, 2'b11, 1'b0, 32'h1111_1111);
        step("b2b_st1", 1'b1, 1'b1, 10'h004, 2'b11, 1'b0, 32'h2222_2222);
        step("b2b_st2", 1'b1, 1'b1, 10'h008, 2'b11, 1'b0, 32'h3333_3333);
        step("b2b_ld0", 1'b1, 1'b0, 10'h000, 2'b11, 1'b1, 32'h0);
        step("b2b_ld1", 1'b1, 1'b0, 10'h004, 2'b11, 1'b1, 32'h0);
        step("b2b_ld2", 1'b1, 1'b0, 10'h008, 2'b11, 1'b1, 32'h0);
        step("b2b_resp0", 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 32'h0);
        step("b2b_resp1", 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 32'h0);
        step("b2b_resp2", 1'b0, 1'b0, 10'h000, 2'b00, 1'b0, 32'h0);

        // Load accepted, reset one cycle later: the response must never appear.
        i_req = 1'b1; i_we = 1'b0; i_addr = 10'h004; i_size = 2'b11; i_unsigned = 1'b1;
        cyc();
        idle();
        cyc();
        i_rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("reset_drop", 64'({o_rvalid, o_err, o_ready, o_rdata}), 64'(0));
        end
        i_rst_n = 1'b1;
        wait_ready("reset_drop_clear_length");

        model_clear();
        for (int i = 0; i < 2000; i++) begin
            logic [9:0] a;
            a = (i % 3 == 0) ? 10'(1016 + $urandom_range(0, 7)) : 10'($urandom_range(0, 63));
            step("rand", 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), a,
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 32'($urandom));
        end
        step("rand_tail", 1'b0, 1'b0, 10'h0, 2'b00, 1'b0, 32'h0);
        step("rand_tail", 1'b0, 1'b0, 10'h0, 2'b00, 1'b0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/dmem_banked.md
DMEM_BANKED -- requirements
Module: dmem_banked

Interface
REQ-001 Parameter ADDR_WIDTH, default 10: byte-address width; depth = 2**ADDR_WIDTH bytes.
REQ-002 Parameter NB_BANKS, default 4: byte banks per word, power of two, 2 to 8; data width = 8*NB_BANKS.
REQ-003 Parameter CLEAR_ON_RESET, default 1: 1 zeroes all banks after reset, 0 skips the clear.
REQ-004 clk  input  1  single clock, rising edge; `clk` is the block's only clock.
REQ-005 i_rst_n  input  1  reset, asynchronous and active-low.
REQ-006 i_req  input  1  access request.
REQ-007 i_we  input  1  1 = store, 0 = load.
REQ-008 i_addr  input  ADDR_WIDTH  byte address.
REQ-009 i_size  input  2  01 = byte, 10 = half, 11 = word; 00 is illegal.
REQ-010 i_unsigned  input  1  1 = zero-extend loads, 0 = sign-extend loads.
REQ-011 i_wdata  input  8*NB_BANKS  store data, LSB-aligned.
REQ-012 o_ready  output  1  request accepted this cycle when high.
REQ-013 o_rvalid  output  1  load response valid, 1-cycle pulse.
REQ-014 o_rdata  output  8*NB_BANKS  load data, aligned and extended.
REQ-015 o_err  output  1  illegal-access pulse.

Function
REQ-016 The block shall accept a request on a rising edge where i_req=1 and o_ready=1; other requests are ignored.
REQ-017 FSM states:
- CLEAR: bank address counter from 0 to depth/NB_BANKS-1, writing zero; o_ready=0.
- RUN: o_ready=1.
REQ-018 FSM transitions: leave reset into CLEAR when CLEAR_ON_RESET=1, else into RUN; go CLEAR->RUN the cycle after the counter hits its last value.
REQ-019 A store shall write exactly the addressed bytes (byte, half or word at any offset), byte k of i_wdata going to address i_addr+k.
REQ-020 Bank b shall use word index (i_addr>>log2(NB_BANKS)) + (b < offset ? 1 : 0), so accesses cross word boundaries.
REQ-021 Crossing the top of memory shall wrap modulo depth.
REQ-022 A load accepted at edge N shall raise o_rvalid for exactly one cycle after edge N+2 (2-cycle latency).
REQ-023 Loads shall be fully pipelined: one load accepted per cycle, one response per cycle, in order.
REQ-024 Load data shall be bytes addr..addr+size-1, right-aligned, extended to full width per i_unsigned.
REQ-025 o_rdata shall be zero whenever o_rvalid=0.
REQ-026 A load at edge N+1 to an address stored at edge N shall return the new data.
REQ-027 i_size=00, or any size larger than NB_BANKS bytes, shall not write.
REQ-028 Such an illegal access shall pulse o_err aligned with where its o_rvalid would be (N+2), with o_rvalid=0.
REQ-029 i_size=00 applies the same illegal-access handling to loads and stores; stores also pulse o_err at N+2.

Reset
REQ-030 While i_rst_n=0, o_ready, o_rvalid and o_err shall be 0 and o_rdata shall be all zeros.
REQ-031 Reset asserted mid-operation shall drop in-flight loads (no o_rvalid) and restart in CLEAR (or RUN) on release.
REQ-032 Reset asserted during CLEAR shall restart the counter at 0.

Configuration
REQ-033 Macro DMEM_MISALIGN_TRAP_EN shall control misaligned accesses (half at odd address, word at non-multiple-of-NB_BANKS address).
REQ-034 With DMEM_MISALIGN_TRAP_EN defined, a misaligned access shall be treated as illegal: no write, o_err pulse, o_rvalid=0.
REQ-035 Without DMEM_MISALIGN_TRAP_EN, misaligned accesses shall complete via REQ-019..REQ-021 and o_err shall flag only REQ-027/REQ-029 cases.

Structure
REQ-036 Package dmem_pkg shall hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state type, and the latency constant RD_LATENCY=2.
REQ-037 Combinational rotate, byte-enable and sign-extend logic shall live in sub-module dmem_align.
REQ-038 Storage shall be NB_BANKS instances of the existing bram bank.

Verification
REQ-039 Reset release, CLEAR_ON_RESET=1, ADDR_WIDTH=10, NB_BANKS=4 -> o_ready=0 for 256 cycles, then 1; a word load at 0x3FC returns 0x00000000.
REQ-040 Store word 0xAABBCCDD at 0x001, then load word at 0x001 -> 0xAABBCCDD after 2 cycles, and the byte at 0x000 is unchanged (no-trap build).
REQ-041 Store byte 0x80 at 0x3FF; load byte signed -> 0xFFFFFF80; load byte unsigned -> 0x00000080.
REQ-042 Store half 0x1234 at 0x3FF -> bytes 0x3FF=0x34 and 0x000=0x12 (wrap); with DMEM_MISALIGN_TRAP_EN -> o_err at N+2 and memory unchanged.
REQ-043 Back-to-back loads at 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive o_rvalid pulses, in order.
REQ-044 Reset asserted one cycle after a load is accepted -> no o_rvalid; CLEAR restarts from 0.
